// File: rtl/clk_rst_seq_gen.sv
// Multi-channel clock-enable divider and staged reset sequencer driven from one clock.
// Each channel has a glitch-free divide update, a software reset hold and a test-mode bypass.
module clk_rst_seq_gen #(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned DIV_W         = 8,
   parameter int unsigned RST_STAGE_CYC = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    testmode_i,
   input  logic [NUM_CH*DIV_W-1:0] div_i,
   input  logic [NUM_CH-1:0]       div_valid_i,
   output logic [NUM_CH-1:0]       div_ack_o,
   input  logic [NUM_CH-1:0]       sw_rst_req_i,
   output logic [NUM_CH-1:0]       clk_en_o,
   output logic [NUM_CH-1:0]       rstn_o,
   output logic                    seq_done_o
);

   localparam int unsigned STG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned CNT_W = $clog2(RST_STAGE_CYC + 1);

   typedef enum logic [1:0] {
      SEQ_WAIT,
      SEQ_REL,
      SEQ_DONE
   } seq_state_e;

   seq_state_e                          state_q, state_d;
   logic [STG_W-1:0]                    stage_q, stage_d;
   logic [CNT_W-1:0]                    count_q, count_d;
   logic [NUM_CH-1:0]                   rel_q, rel_d;
   logic                                seq_done_q, seq_done_d;

   logic [NUM_CH-1:0][CNT_W-1:0]        hold_q, hold_d;
   logic [NUM_CH-1:0]                   rstn_q, rstn_d;
   logic [NUM_CH-1:0][DIV_W-1:0]        cnt_q, cnt_d;
   logic [NUM_CH-1:0][DIV_W-1:0]        d_reg_q, d_reg_d;
   logic [NUM_CH-1:0][DIV_W-1:0]        pend_val_q, pend_val_d;
   logic [NUM_CH-1:0]                   pend_q, pend_d;
   logic [NUM_CH-1:0]                   en_q, en_d;
   logic [NUM_CH-1:0]                   ack_q, ack_d;
   logic [NUM_CH-1:0]                   wrap_c, load_c;

   // Power-on release sequencer. The REL cycle counts as the first cycle of the
   // next stage so consecutive releases land exactly RST_STAGE_CYC cycles apart.
   always_comb begin
      state_d    = state_q;
      stage_d    = stage_q;
      count_d    = count_q;
      rel_d      = rel_q;
      seq_done_d = seq_done_q;
      case (state_q)
         SEQ_WAIT: begin
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(RST_STAGE_CYC - 1)) begin
               state_d = SEQ_REL;
            end
         end
         SEQ_REL: begin
            rel_d[stage_q] = 1'b1;
            count_d        = CNT_W'(1);
            if (stage_q == STG_W'(NUM_CH - 1)) begin
               state_d    = SEQ_DONE;
               seq_done_d = 1'b1;
            end else begin
               stage_d = stage_q + STG_W'(1);
               state_d = SEQ_WAIT;
            end
         end
         SEQ_DONE: begin
            state_d = SEQ_DONE;
         end
         default: begin
            state_d = SEQ_WAIT;
         end
      endcase
   end

   // A pending value is taken at a period boundary, or straight away while held in reset.
   always_comb begin
      wrap_c = '0;
      load_c = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         wrap_c[k] = rstn_q[k] & (cnt_q[k] == d_reg_q[k]);
         load_c[k] = pend_q[k] & (wrap_c[k] | ~rstn_q[k]);
      end
   end

   always_comb begin
      hold_d     = hold_q;
      rstn_d     = '0;
      cnt_d      = cnt_q;
      d_reg_d    = d_reg_q;
      pend_val_d = pend_val_q;
      pend_d     = pend_q;
      en_d       = '0;
      ack_d      = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (seq_done_q && sw_rst_req_i[k]) begin
            hold_d[k] = CNT_W'(RST_STAGE_CYC);
         end else if (hold_q[k] != '0) begin
            hold_d[k] = hold_q[k] - CNT_W'(1);
         end
         rstn_d[k] = rel_d[k] & (hold_d[k] == '0);

         if (!rstn_q[k] || wrap_c[k]) begin
            cnt_d[k] = '0;
         end else begin
            cnt_d[k] = cnt_q[k] + DIV_W'(1);
         end
         en_d[k] = wrap_c[k];

         if (load_c[k]) begin
            d_reg_d[k] = pend_val_q[k];
         end
         ack_d[k]  = load_c[k];
         pend_d[k] = div_valid_i[k] | (pend_q[k] & ~load_c[k]);
         if (div_valid_i[k]) begin
            pend_val_d[k] = div_i[k*DIV_W +: DIV_W];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= SEQ_WAIT;
         stage_q    <= '0;
         count_q    <= '0;
         rel_q      <= '0;
         seq_done_q <= 1'b0;
         hold_q     <= '0;
         rstn_q     <= '0;
         cnt_q      <= '0;
         d_reg_q    <= '0;
         pend_val_q <= '0;
         pend_q     <= '0;
         en_q       <= '0;
         ack_q      <= '0;
      end else begin
         state_q    <= state_d;
         stage_q    <= stage_d;
         count_q    <= count_d;
         rel_q      <= rel_d;
         seq_done_q <= seq_done_d;
         hold_q     <= hold_d;
         rstn_q     <= rstn_d;
         cnt_q      <= cnt_d;
         d_reg_q    <= d_reg_d;
         pend_val_q <= pend_val_d;
         pend_q     <= pend_d;
         en_q       <= en_d;
         ack_q      <= ack_d;
      end
   end

   // Test mode overrides only the outputs; internal state keeps running underneath.
   assign rstn_o     = testmode_i ? {NUM_CH{~rst_i}} : rstn_q;
   assign clk_en_o   = testmode_i ? {NUM_CH{1'b1}} : en_q;
   assign div_ack_o  = ack_q;
   assign seq_done_o = seq_done_q;

endmodule
